// File: rtl/mma_result_drain.sv
// mma_result_drain
// Captures one FP32 result tile from tensor_core_fp16_mma, converts every
// element to FP16 (round-to-nearest-even) and streams it out one row per
// valid/ready beat. d_ready tells the core when a new tile can be accepted.
//
// Build option: define DRAIN_SAT_EN to saturate overflowing finite inputs to
// +/-65504 instead of +/-Inf. ovf_sticky is set in both builds.
//
// state | meaning
// IDLE  | no tile held, d_ready=1, waiting for result_valid
// LOAD  | tile captured, converting row 0 into the output register
// SEND  | a row beat is presented, waiting for out_ready
`timescale 1ns/1ps

module mma_result_drain #(
    parameter  int M  = 4,
    parameter  int N  = 4,
    localparam int RW = (M > 1) ? $clog2(M) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              result_valid,
    input  logic [31:0]       matrix_d [M*N],
    output logic              d_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [16*N-1:0]   out_data,
    output logic [RW-1:0]     out_row,
    output logic              out_last,
    input  logic              status_clr,
    output logic              ovf_sticky,
    output logic              drop_sticky
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [31:0]       cap_q [M*N];
    logic              out_valid_q, out_valid_d;
    logic [16*N-1:0]   out_data_q, out_data_d;
    logic [RW-1:0]     out_row_q, out_row_d;
    logic              out_last_q, out_last_d;
    logic              ovf_q, ovf_d;
    logic              drop_q, drop_d;

    logic              capture_en;
    logic              load_en;
    logic [RW-1:0]     load_row;
    logic [16*N-1:0]   row_data;
    logic              row_ovf;
    logic [16:0]       cv;

    // Returns {overflow, fp16}. Overflow only flags finite inputs that exceed
    // the FP16 range after rounding; Inf and NaN never raise it.
    function automatic logic [16:0] fp32_to_fp16(input logic [31:0] x);
        logic        s;
        logic [7:0]  e;
        logic [22:0] f;
        logic [15:0] ovf_res;
        logic [16:0] res;
        logic [14:0] mag;
        logic        rnd;
        logic [23:0] sig;
        logic [4:0]  sh_amt;
        logic [4:0]  g_idx;
        logic [23:0] mask;
        logic [9:0]  sub_m;
        int          u;
        s = x[31];
        e = x[30:23];
        f = x[22:0];
`ifdef DRAIN_SAT_EN
        ovf_res = {s, 15'h7BFF};
`else
        ovf_res = {s, 15'h7C00};
`endif
        u      = int'(e) - 127;
        res    = {1'b0, s, 15'h0};
        mag    = '0;
        rnd    = 1'b0;
        sig    = '0;
        sh_amt = '0;
        g_idx  = '0;
        mask   = '0;
        sub_m  = '0;
        if (e == 8'hFF) begin
            res = (f != 23'h0) ? 17'h07E00 : {1'b0, s, 15'h7C00};
        end else if (e == 8'h00) begin
            res = {1'b0, s, 15'h0};
        end else if (u > 15) begin
            res = {1'b1, ovf_res};
        end else if (u >= -14) begin
            mag = {5'(u + 15), f[22:13]};
            rnd = f[12] & ((|f[11:0]) | f[13]);
            mag = mag + 15'(rnd);
            if (mag[14:10] == 5'h1F) res = {1'b1, ovf_res};
            else                     res = {1'b0, s, mag};
        end else if (u >= -25) begin
            // Value in units of 2^-24 is {1,f} >> (13 + (-14-u)).
            sig    = {1'b1, f};
            sh_amt = 5'(-1 - u);
            g_idx  = 5'(-2 - u);
            mask   = (24'd1 << g_idx) - 24'd1;
            sub_m  = 10'(sig >> sh_amt);
            rnd    = sig[g_idx] & ((|(sig & mask)) | sub_m[0]);
            // A carry out of 0x3FF lands on 0x400, the minimum normal.
            mag    = {5'h0, sub_m} + 15'(rnd);
            res    = {1'b0, s, mag};
        end
        return res;
    endfunction

    // Row selection, conversion, FSM and output register next-state.
    always_comb begin
        capture_en = (state_q == ST_IDLE) && result_valid;
        load_row   = (state_q == ST_LOAD) ? '0 : RW'(out_row_q + 1'b1);
        row_data   = '0;
        row_ovf    = 1'b0;
        cv         = '0;
        for (int c = 0; c < N; c++) begin
            cv = fp32_to_fp16(cap_q[int'(load_row) * N + c]);
            row_data[16*c +: 16] = cv[15:0];
            row_ovf = row_ovf | cv[16];
        end

        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_row_d   = out_row_q;
        out_last_d  = out_last_q;
        load_en     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (result_valid) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                load_en = 1'b1;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (out_ready) begin
                    if (out_last_q) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = ST_IDLE;
                    end else begin
                        load_en = 1'b1;
                    end
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
        if (load_en) begin
            out_valid_d = 1'b1;
            out_data_d  = row_data;
            out_row_d   = load_row;
            out_last_d  = (load_row == RW'(M - 1));
        end

        // Set wins over a simultaneous clear.
        ovf_d  = (load_en & row_ovf) | (ovf_q & ~status_clr);
        drop_d = (result_valid && (state_q != ST_IDLE)) | (drop_q & ~status_clr);
    end

    // State, output beat and sticky flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_row_q   <= '0;
            out_last_q  <= 1'b0;
            ovf_q       <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_row_q   <= out_row_d;
            out_last_q  <= out_last_d;
            ovf_q       <= ovf_d;
            drop_q      <= drop_d;
        end
    end

    // Tile capture; only written while idle so a busy strobe cannot corrupt it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < M*N; i++) cap_q[i] <= '0;
        end else if (capture_en) begin
            for (int i = 0; i < M*N; i++) cap_q[i] <= matrix_d[i];
        end
    end

    assign d_ready     = (state_q == ST_IDLE);
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_row     = out_row_q;
    assign out_last    = out_last_q;
    assign ovf_sticky  = ovf_q;
    assign drop_sticky = drop_q;

endmodule

// File: tb/tb_mma_result_drain.sv
// Self-checking bench for mma_result_drain: directed tiles plus randomized
// tiles with random backpressure, checked against a real-arithmetic model.
`timescale 1ns/1ps

module tb_mma_result_drain;

    localparam int M  = 4;
    localparam int N  = 4;
    localparam int RW = 2;
`ifdef DRAIN_SAT_EN
    localparam logic [14:0] OVF_MAG = 15'h7BFF;
`else
    localparam logic [14:0] OVF_MAG = 15'h7C00;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              result_valid = 1'b0;
    logic              out_ready = 1'b1;
    logic              status_clr = 1'b0;
    logic [31:0]       matrix_d [M*N];
    logic              d_ready, out_valid, out_last, ovf_sticky, drop_sticky;
    logic [16*N-1:0]   out_data;
    logic [RW-1:0]     out_row;

    typedef struct packed {
        logic [63:0]   data;
        logic [RW-1:0] row;
    } beat_t;

    beat_t       exp_q [$];
    logic [31:0] tile [M*N];
    logic [63:0] got_data [M];
    int          n_checks = 0;
    int          n_errors = 0;
    int          beats_seen = 0;
    int          busy_cnt = 0;
    int          last_row_seen = -1;
    bit          model_ovf = 1'b0;
    int          b0, n0;

    mma_result_drain #(.M(M), .N(N)) dut (
        .clk(clk), .rst_n(rst_n), .result_valid(result_valid), .matrix_d(matrix_d),
        .d_ready(d_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_row(out_row), .out_last(out_last),
        .status_clr(status_clr), .ovf_sticky(ovf_sticky), .drop_sticky(drop_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int rne(input real q);
        real fl;
        real d;
        int  n;
        fl = $floor(q);
        n  = $rtoi(fl);
        d  = q - fl;
        if (d > 0.5 || (d == 0.5 && n[0] == 1'b1)) n++;
        return n;
    endfunction

    // Reference: evaluate the FP32 value exactly as a real, then pick the
    // nearest FP16 (ties to even). Returns {overflow, fp16}.
    function automatic logic [16:0] ref_cvt(input logic [31:0] x);
        logic s;
        int   e, f, ex, n;
        real  v, p;
        s = x[31];
        e = int'(x[30:23]);
        f = int'(x[22:0]);
        if (e == 255) return (f != 0) ? 17'h07E00 : {1'b0, s, 15'h7C00};
        if (e == 0) return {1'b0, s, 15'h0};
        v = 1.0 + real'(f) / 8388608.0;
        for (int i = 127; i < e; i++) v = v * 2.0;
        for (int i = e; i < 127; i++) v = v / 2.0;
        if (v >= 65520.0) return {1'b1, s, OVF_MAG};
        if (v < 1.0 / 16384.0) begin
            n = rne(v * 16777216.0);
            return {1'b0, s, 15'(n)};
        end
        p  = 1.0 / 16384.0;
        ex = -14;
        while (v >= p * 2.0) begin
            p = p * 2.0;
            ex++;
        end
        n = rne(v / p * 1024.0);
        if (n == 2048) begin
            n = 1024;
            ex++;
        end
        return {1'b0, s, 5'(ex + 15), 10'(n - 1024)};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [7:0]  e;
        logic [22:0] f;
        int          k;
        k = $urandom_range(0, 15);
        if (k == 0)      e = 8'h00;
        else if (k == 1) e = 8'hFF;
        else             e = 8'($urandom_range(97, 145));
        f = 23'($urandom);
        if ($urandom_range(0, 3) == 0) f[12:0] = 13'h1000;
        if (k == 1 && $urandom_range(0, 1) == 0) f = '0;
        return {1'($urandom), e, f};
    endfunction

    task automatic push_expected();
        beat_t       b;
        logic [16:0] r;
        for (int row = 0; row < M; row++) begin
            b.data = '0;
            b.row  = RW'(row);
            for (int c = 0; c < N; c++) begin
                r = ref_cvt(tile[row*N + c]);
                b.data[16*c +: 16] = r[15:0];
                if (r[16]) model_ovf = 1'b1;
            end
            exp_q.push_back(b);
        end
    endtask

    // Observes the output port at every falling edge: scoreboard, stall
    // stability and next-row timing.
    task automatic monitor();
        bit            hold = 1'b0;
        bit            after_hs = 1'b0;
        logic [63:0]   hold_data = '0;
        logic [RW-1:0] hold_row = '0;
        int            hs_row = 0;
        beat_t         b;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold     = 1'b0;
                after_hs = 1'b0;
            end else begin
                if (hold) begin
                    chk("stall_valid", 64'(out_valid), 64'd1);
                    chk("stall_data", out_data, hold_data);
                    chk("stall_row", 64'(out_row), 64'(hold_row));
                end
                if (after_hs) begin
                    if (hs_row < M-1) chk("next_row", 64'({out_valid, out_row}), 64'({1'b1, RW'(hs_row + 1)}));
                    else              chk("end_valid", 64'(out_valid), 64'd0);
                end
                hold     = 1'b0;
                after_hs = 1'b0;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 64'(out_valid), 64'd0);
                    end else begin
                        b = exp_q.pop_front();
                        chk("beat_row", 64'(out_row), 64'(b.row));
                        chk("beat_data", out_data, b.data);
                        chk("beat_last", 64'(out_last), 64'(b.row == RW'(M-1)));
                    end
                    got_data[out_row] = out_data;
                    if (out_last) last_row_seen = int'(out_row);
                    beats_seen++;
                    after_hs = 1'b1;
                    hs_row   = int'(out_row);
                end else if (out_valid) begin
                    hold      = 1'b1;
                    hold_data = out_data;
                    hold_row  = out_row;
                end
                if (!d_ready) busy_cnt++;
            end
        end
    endtask

    task automatic send_tile();
        int t = 0;
        while (!d_ready && t < 200) begin
            @(posedge clk); #2;
            t++;
        end
        if (!d_ready) chk("idle_timeout", 64'(d_ready), 64'd1);
        for (int i = 0; i < M*N; i++) matrix_d[i] = tile[i];
        result_valid = 1'b1;
        push_expected();
        @(posedge clk); #2;
        result_valid = 1'b0;
    endtask

    task automatic wait_drain(input bit rand_rdy);
        int t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 300) begin
            @(posedge clk); #2;
            t++;
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
        chk("drain_timeout", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #2;
    endtask

    task automatic wait_row(input int r);
        int t = 0;
        while (!(out_valid && int'(out_row) == r) && t < 50) begin
            @(posedge clk); #2;
            t++;
        end
        chk("wait_row", 64'({out_valid, out_row}), 64'({1'b1, RW'(r)}));
    endtask

    task automatic clear_status();
        status_clr = 1'b1;
        @(posedge clk); #2;
        status_clr = 1'b0;
        model_ovf  = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < M*N; i++) matrix_d[i] = '0;
        fork
            monitor();
        join_none

        // Reset values
        #12;
        chk("rst_d_ready", 64'(d_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_row", 64'(out_row), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_ovf", 64'(ovf_sticky), 64'd0);
        chk("rst_drop", 64'(drop_sticky), 64'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #2;

        // Smoke tile from the core test
        for (int i = 0; i < M*N; i++) tile[i] = 32'h40A00000;
        tile[0]  = 32'h41000000;
        tile[8]  = 32'h40E00000;
        tile[10] = 32'h41200000;
        b0 = busy_cnt;
        n0 = beats_seen;
        send_tile();
        @(negedge clk);
        chk("lat_capture", 64'({out_valid, d_ready}), 64'd0);
        @(negedge clk);
        chk("lat_first", 64'({out_valid, out_row}), 64'({1'b1, RW'(0)}));
        wait_drain(1'b0);
        chk("smoke_busy", 64'(busy_cnt - b0), 64'd5);
        chk("smoke_beats", 64'(beats_seen - n0), 64'd4);
        chk("smoke_row0", got_data[0], 64'h4500_4500_4500_4800);
        chk("smoke_row2", got_data[2], 64'h4500_4900_4500_4700);
        chk("smoke_last", 64'(last_row_seen), 64'd3);

        // Rounding corners
        for (int i = 0; i < M*N; i++) tile[i] = {1'($urandom), 8'($urandom_range(100, 140)), 23'($urandom)};
        tile[0] = 32'h3F801000;
        tile[1] = 32'h3F803000;
        tile[2] = 32'h33800000;
        tile[3] = 32'h33000000;
        tile[4] = 32'h387FE000;
        tile[5] = 32'h7FC00000;
        tile[6] = 32'hFF800000;
        send_tile();
        wait_drain(1'b0);
        chk("rne_tie_even", 64'(got_data[0][15:0]), 64'h3C00);
        chk("rne_up", 64'(got_data[0][31:16]), 64'h3C02);
        chk("sub_min", 64'(got_data[0][47:32]), 64'h0001);
        chk("sub_tie_zero", 64'(got_data[0][63:48]), 64'h0000);
        chk("sub_to_normal", 64'(got_data[1][15:0]), 64'h0400);
        chk("nan", 64'(got_data[1][31:16]), 64'h7E00);
        chk("neg_inf", 64'(got_data[1][47:32]), 64'hFC00);
        chk("round_ovf_clear", 64'(ovf_sticky), 64'd0);

        // Overflow handling and status clear
        for (int i = 0; i < M*N; i++) tile[i] = {1'($urandom), 8'($urandom_range(100, 140)), 23'($urandom)};
        tile[0] = 32'h4788B800;
        tile[1] = 32'h477FF000;
        tile[2] = 32'hC788B800;
        tile[3] = 32'h477FE000;
        send_tile();
        wait_drain(1'b0);
        chk("ovf_70000", 64'(got_data[0][15:0]), 64'({1'b0, OVF_MAG}));
        chk("ovf_65520", 64'(got_data[0][31:16]), 64'({1'b0, OVF_MAG}));
        chk("ovf_neg", 64'(got_data[0][47:32]), 64'({1'b1, OVF_MAG}));
        chk("max_finite", 64'(got_data[0][63:48]), 64'h7BFF);
        chk("ovf_set", 64'(ovf_sticky), 64'd1);
        clear_status();
        chk("ovf_cleared", 64'(ovf_sticky), 64'd0);

        // Backpressure on the row 1 beat
        for (int i = 0; i < M*N; i++) tile[i] = rand_fp();
        n0 = beats_seen;
        send_tile();
        wait_row(1);
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("bp_held_row", 64'({out_valid, out_row}), 64'({1'b1, RW'(1)}));
        out_ready = 1'b1;
        wait_drain(1'b0);
        chk("bp_beats", 64'(beats_seen - n0), 64'd4);
        clear_status();

        // Busy drop during row 2
        for (int i = 0; i < M*N; i++) tile[i] = rand_fp();
        n0 = beats_seen;
        send_tile();
        wait_row(2);
        for (int i = 0; i < M*N; i++) matrix_d[i] = 32'h3F800000;
        result_valid = 1'b1;
        @(posedge clk); #2;
        result_valid = 1'b0;
        wait_drain(1'b0);
        chk("drop_set", 64'(drop_sticky), 64'd1);
        repeat (8) @(posedge clk);
        #2;
        chk("drop_no_second", 64'(beats_seen - n0), 64'd4);
        chk("drop_idle", 64'({out_valid, d_ready}), 64'd1);
        clear_status();
        chk("drop_cleared", 64'(drop_sticky), 64'd0);

        // Asynchronous reset while the row 1 beat is pending
        for (int i = 0; i < M*N; i++) tile[i] = rand_fp();
        send_tile();
        wait_row(1);
        out_ready = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_ready", 64'(d_ready), 64'd1);
        exp_q.delete();
        model_ovf = 1'b0;
        @(negedge clk);
        @(posedge clk); #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        chk("rst_mid_flags", 64'({ovf_sticky, drop_sticky}), 64'd0);
        for (int i = 0; i < M*N; i++) tile[i] = rand_fp();
        n0 = beats_seen;
        send_tile();
        wait_drain(1'b0);
        chk("post_rst_beats", 64'(beats_seen - n0), 64'd4);
        clear_status();

        // Randomized tiles with random backpressure
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < M*N; i++) tile[i] = rand_fp();
            send_tile();
            wait_drain(1'b1);
            chk("rand_ovf", 64'(ovf_sticky), 64'(model_ovf));
            clear_status();
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
